ex_result_ctrl: RTL and testbench

EX-stage result controller. It accepts one decoded operation at a time, launches the multi-cycle multiplier or divider when needed, and waits for their completion handshake. It drives the registered one-hot `select` that picks the EX result (adder / multiplier / divider / logic / hilo) and presents a valid/ready handshake to the EX/MEM boundary. It is the producer side of the EX result-select interface and supplies the stall that freezes the upstream pipeline.

---
 rtl/ex_result_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_ex_result_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ex_result_ctrl.sv
// EX-stage result controller: accepts one decoded op, sequences the multi-cycle
// multiplier/divider handshakes and drives the registered one-hot result select.
module ex_result_ctrl #(
    parameter int unsigned WATCHDOG = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       op_valid,
    input  logic [4:0] op_class,
    output logic       in_ready,
    output logic       mul_start,
    input  logic       mul_done,
    output logic       div_start,
    input  logic       div_done,
    output logic       div_cancel,
    output logic [4:0] select,
    output logic       result_valid,
    input  logic       out_ready,
    output logic       illegal_op,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MUL = 2'd1,
        WAIT_DIV = 2'd2,
        RESULT   = 2'd3
    } state_t;

    localparam logic [4:0] SEL_NONE = 5'b00000;
    localparam logic [4:0] SEL_MUL  = 5'b00010;
    localparam logic [4:0] SEL_DIV  = 5'b00100;
    localparam logic [7:0] WD_LAST  = 8'(WATCHDOG - 32'd1);

    function automatic logic is_one_hot(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

    state_t     state_r, state_n_s;
    logic [4:0] select_r, select_n_s;
    logic [7:0] cnt_r, cnt_n_s;
    logic       mul_start_r, mul_start_n_s;
    logic       div_start_r, div_start_n_s;
    logic       div_cancel_r, div_cancel_n_s;
    logic       illegal_r, illegal_n_s;
    logic       timeout_r, timeout_n_s;
    logic       result_valid_r;

    state_t     dec_state_s;
    logic [4:0] dec_select_s;
    logic       dec_mul_s, dec_div_s, dec_illegal_s;
    logic       in_ready_s, accept_s;

    assign in_ready_s = (state_r == IDLE) || ((state_r == RESULT) && out_ready);
    assign accept_s   = op_valid && in_ready_s;

    // Decode the requested unit into launch actions.
    always_comb begin
        dec_state_s   = RESULT;
        dec_select_s  = SEL_NONE;
        dec_mul_s     = 1'b0;
        dec_div_s     = 1'b0;
        dec_illegal_s = 1'b0;
        if (!is_one_hot(op_class)) begin
            dec_illegal_s = 1'b1;
        end else if (op_class == SEL_MUL) begin
            dec_state_s  = WAIT_MUL;
            dec_select_s = SEL_MUL;
            dec_mul_s    = 1'b1;
        end else if (op_class == SEL_DIV) begin
            dec_state_s  = WAIT_DIV;
            dec_select_s = SEL_DIV;
            dec_div_s    = 1'b1;
        end else begin
            dec_select_s = op_class;
        end
    end

    // Next-state and next-output logic; flush overrides everything else.
    always_comb begin
        state_n_s      = state_r;
        select_n_s     = select_r;
        cnt_n_s        = cnt_r;
        mul_start_n_s  = 1'b0;
        div_start_n_s  = 1'b0;
        div_cancel_n_s = 1'b0;
        illegal_n_s    = 1'b0;
        timeout_n_s    = 1'b0;
        case (state_r)
            IDLE, RESULT: begin
                if (accept_s) begin
                    state_n_s     = dec_state_s;
                    select_n_s    = dec_select_s;
                    mul_start_n_s = dec_mul_s;
                    div_start_n_s = dec_div_s;
                    illegal_n_s   = dec_illegal_s;
                    cnt_n_s       = 8'd0;
                end else if ((state_r == RESULT) && out_ready) begin
                    state_n_s  = IDLE;
                    select_n_s = SEL_NONE;
                end else begin
                    state_n_s = state_r;
                end
            end
            WAIT_MUL: begin
                if (mul_done) begin
                    state_n_s = RESULT;
                end else if (cnt_r == WD_LAST) begin
                    state_n_s   = RESULT;
                    select_n_s  = SEL_NONE;
                    timeout_n_s = 1'b1;
                end else begin
                    cnt_n_s = cnt_r + 8'd1;
                end
            end
            WAIT_DIV: begin
                if (div_done) begin
                    state_n_s = RESULT;
                end else if (cnt_r == WD_LAST) begin
                    state_n_s      = RESULT;
                    select_n_s     = SEL_NONE;
                    timeout_n_s    = 1'b1;
                    div_cancel_n_s = 1'b1;
                end else begin
                    cnt_n_s = cnt_r + 8'd1;
                end
            end
            default: begin
                state_n_s  = IDLE;
                select_n_s = SEL_NONE;
            end
        endcase
        if (flush) begin
            state_n_s      = IDLE;
            select_n_s     = SEL_NONE;
            cnt_n_s        = 8'd0;
            mul_start_n_s  = 1'b0;
            div_start_n_s  = 1'b0;
            illegal_n_s    = 1'b0;
            timeout_n_s    = 1'b0;
            div_cancel_n_s = (state_r == WAIT_DIV);
        end else begin
            state_n_s = state_n_s;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            select_r       <= SEL_NONE;
            cnt_r          <= 8'd0;
            mul_start_r    <= 1'b0;
            div_start_r    <= 1'b0;
            div_cancel_r   <= 1'b0;
            illegal_r      <= 1'b0;
            timeout_r      <= 1'b0;
            result_valid_r <= 1'b0;
        end else begin
            state_r        <= state_n_s;
            select_r       <= select_n_s;
            cnt_r          <= cnt_n_s;
            mul_start_r    <= mul_start_n_s;
            div_start_r    <= div_start_n_s;
            div_cancel_r   <= div_cancel_n_s;
            illegal_r      <= illegal_n_s;
            timeout_r      <= timeout_n_s;
            result_valid_r <= (state_n_s == RESULT);
        end
    end

    assign in_ready     = in_ready_s;
    assign select       = select_r;
    assign result_valid = result_valid_r;
    assign mul_start    = mul_start_r;
    assign div_start    = div_start_r;
    assign div_cancel   = div_cancel_r;
    assign illegal_op   = illegal_r;
    assign timeout_err  = timeout_r;

    ex_result_ctrl_chk u_chk (
        .clk          (clk),
        .rst          (rst),
        .select       (select_r),
        .result_valid (result_valid_r),
        .mul_start    (mul_start_r),
        .div_start    (div_start_r),
        .div_cancel   (div_cancel_r),
        .timeout_err  (timeout_r)
    );

endmodule

// Invariant checker for the result-select interface outputs.
module ex_result_ctrl_chk (
    input logic       clk,
    input logic       rst,
    input logic [4:0] select,
    input logic       result_valid,
    input logic       mul_start,
    input logic       div_start,
    input logic       div_cancel,
    input logic       timeout_err
);

    a_sel_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(select));
    a_mul_pulse:   assert property (@(posedge clk) disable iff (rst) mul_start |=> !mul_start);
    a_div_pulse:   assert property (@(posedge clk) disable iff (rst) div_start |=> !div_start);
    a_cancel_pulse: assert property (@(posedge clk) disable iff (rst) div_cancel |=> !div_cancel);
    a_tmo_pulse:   assert property (@(posedge clk) disable iff (rst) timeout_err |=> !timeout_err);
    a_mul_sel:     assert property (@(posedge clk) disable iff (rst) mul_start |-> (select == 5'b00010));
    a_div_sel:     assert property (@(posedge clk) disable iff (rst) div_start |-> (select == 5'b00100));
    a_tmo_res:     assert property (@(posedge clk) disable iff (rst)
                                    timeout_err |-> (result_valid && (select == 5'b00000)));

endmodule

// File: tb/tb_ex_result_ctrl.sv
// Directed bench for ex_result_ctrl with hand-computed expectations (WATCHDOG=8).
module tb_ex_result_ctrl;

    logic       clk = 1'b0;
    logic       rst, flush, op_valid, mul_done, div_done, out_ready;
    logic [4:0] op_class;
    logic       in_ready, mul_start, div_start, div_cancel, result_valid, illegal_op, timeout_err;
    logic [4:0] select;

    int checks = 0;
    int errors = 0;

    ex_result_ctrl #(.WATCHDOG(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .op_class(op_class),
        .in_ready(in_ready), .mul_start(mul_start), .mul_done(mul_done),
        .div_start(div_start), .div_done(div_done), .div_cancel(div_cancel),
        .select(select), .result_valid(result_valid), .out_ready(out_ready),
        .illegal_op(illegal_op), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Advance past one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op_class = 5'd0;
        mul_done = 1'b0; div_done = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (select !== 5'b00000) begin errors++; $display("FAIL reset_select got %b want %b", select, 5'b00000); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", result_valid); end
        checks++; if ({mul_start, div_start, div_cancel, illegal_op, timeout_err} !== 5'b00000) begin
            errors++; $display("FAIL reset_pulses got %b want 00000", {mul_start, div_start, div_cancel, illegal_op, timeout_err}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; op_valid = 1'b1; op_class = 5'b00001;
        tick();
        checks++; if (select !== 5'b00001) begin errors++; $display("FAIL b2b_add_sel got %b want 00001", select); end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL b2b_add_valid got %b want 1", result_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
        op_class = 5'b01000;
        tick();
        checks++; if (select !== 5'b01000) begin errors++; $display("FAIL b2b_logic_sel got %b want 01000", select); end
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL b2b_logic_valid got %b want 1", result_valid); end
        op_class = 5'b10000;
        tick();
        checks++; if (select !== 5'b10000) begin errors++; $display("FAIL b2b_hilo_sel got %b want 10000", select); end
        op_valid = 1'b0;
        tick();
        checks++; if ({result_valid, select} !== 6'b0_00000) begin
            errors++; $display("FAIL b2b_drain got %b want 000000", {result_valid, select}); end
    endtask

    task automatic test_mul();
        out_ready = 1'b1; op_valid = 1'b1; op_class = 5'b00010;
        tick();
        op_valid = 1'b0;
        checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL mul_start_c2 got %b want 1", mul_start); end
        checks++; if (select !== 5'b00010) begin errors++; $display("FAIL mul_sel_c2 got %b want 00010", select); end
        checks++; if ({in_ready, result_valid} !== 2'b00) begin errors++; $display("FAIL mul_busy_c2 got %b want 00", {in_ready, result_valid}); end
        tick();
        checks++; if ({mul_start, in_ready} !== 2'b00) begin errors++; $display("FAIL mul_c3 got %b want 00", {mul_start, in_ready}); end
        tick(); tick();
        mul_done = 1'b1;
        checks++; if ({in_ready, result_valid} !== 2'b00) begin errors++; $display("FAIL mul_busy_c5 got %b want 00", {in_ready, result_valid}); end
        tick();
        mul_done = 1'b0;
        checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL mul_valid_c6 got %b want 1", result_valid); end
        checks++; if (select !== 5'b00010) begin errors++; $display("FAIL mul_sel_c6 got %b want 00010", select); end
        tick();
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL mul_drain got %b want 0", result_valid); end
    endtask

    task automatic test_div_hold();
        out_ready = 1'b0; op_valid = 1'b1; op_class = 5'b00100;
        tick();
        op_valid = 1'b0;
        checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL div_start_c2 got %b want 1", div_start); end
        tick();
        div_done = 1'b1;
        tick();
        op_valid = 1'b1; op_class = 5'b00001;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({result_valid, select, in_ready} !== 7'b1_00100_0) begin
                errors++; $display("FAIL div_hold_%0d got %b want 1001000", i, {result_valid, select, in_ready}); end
            tick();
        end
        op_valid = 1'b0; out_ready = 1'b1; div_done = 1'b0;
        tick();
        checks++; if ({result_valid, select} !== 6'b0_00000) begin
            errors++; $display("FAIL div_drain got %b want 000000", {result_valid, select}); end
    endtask

    task automatic test_timeout();
        out_ready = 1'b0; op_valid = 1'b1; op_class = 5'b00100;
        tick();
        op_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checks++; if ({timeout_err, result_valid} !== 2'b00) begin
            errors++; $display("FAIL tmo_c9 got %b want 00", {timeout_err, result_valid}); end
        tick();
        checks++; if ({timeout_err, div_cancel, result_valid} !== 3'b111) begin
            errors++; $display("FAIL tmo_c10_flags got %b want 111", {timeout_err, div_cancel, result_valid}); end
        checks++; if (select !== 5'b00000) begin errors++; $display("FAIL tmo_c10_sel got %b want 00000", select); end
        tick();
        checks++; if ({timeout_err, div_cancel, result_valid} !== 3'b001) begin
            errors++; $display("FAIL tmo_c11 got %b want 001", {timeout_err, div_cancel, result_valid}); end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_done_at_limit();
        out_ready = 1'b1; op_valid = 1'b1; op_class = 5'b00100;
        tick();
        op_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        div_done = 1'b1;
        tick();
        div_done = 1'b0;
        checks++; if ({timeout_err, div_cancel, result_valid, select} !== 8'b001_00100) begin
            errors++; $display("FAIL done_at_limit got %b want 00100100", {timeout_err, div_cancel, result_valid, select}); end
        tick();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1; op_valid = 1'b1; op_class = 5'b00110;
        tick();
        checks++; if ({illegal_op, result_valid, select} !== 7'b11_00000) begin
            errors++; $display("FAIL illegal_multi got %b want 1100000", {illegal_op, result_valid, select}); end
        op_class = 5'b00000;
        tick();
        checks++; if ({illegal_op, result_valid, select} !== 7'b11_00000) begin
            errors++; $display("FAIL illegal_zero got %b want 1100000", {illegal_op, result_valid, select}); end
        op_valid = 1'b0;
        tick();
        checks++; if ({illegal_op, result_valid} !== 2'b00) begin
            errors++; $display("FAIL illegal_clear got %b want 00", {illegal_op, result_valid}); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1; op_valid = 1'b1; op_class = 5'b00100;
        tick();
        op_valid = 1'b0;
        tick(); tick();
        flush = 1'b1; div_done = 1'b1;
        tick();
        flush = 1'b0; div_done = 1'b0;
        checks++; if ({result_valid, div_cancel, in_ready, select} !== 8'b011_00000) begin
            errors++; $display("FAIL flush_div got %b want 01100000", {result_valid, div_cancel, in_ready, select}); end
        mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
        checks++; if ({result_valid, mul_start, in_ready, select} !== 8'b001_00000) begin
            errors++; $display("FAIL stray_mul_done got %b want 00100000", {result_valid, mul_start, in_ready, select}); end
        op_valid = 1'b1; op_class = 5'b00010; flush = 1'b1;
        tick();
        op_valid = 1'b0; flush = 1'b0;
        checks++; if ({mul_start, result_valid, in_ready, select} !== 8'b001_00000) begin
            errors++; $display("FAIL flush_vs_accept got %b want 00100000", {mul_start, result_valid, in_ready, select}); end
        op_valid = 1'b1; op_class = 5'b00010;
        tick();
        op_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
        checks++; if ({result_valid, div_cancel, in_ready} !== 3'b001) begin
            errors++; $display("FAIL flush_mul_late_done got %b want 001", {result_valid, div_cancel, in_ready}); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mul();
        test_div_hold();
        test_timeout();
        test_done_at_limit();
        test_illegal();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit got running want finished");
        $fatal(1);
    end

endmodule
